// File: rtl/piso_bit_serializer_if.sv
// piso_bit_serializer_if: parallel-load handshake plus serial output bundle.
// The master drives words in. The slave serializes them.
interface piso_bit_serializer_if #(parameter int WIDTH = 8);
  logic load_valid;
  logic [WIDTH-1:0] load_data;
  logic load_ready;
  logic ser_out, ser_valid, frame_start, frame_last, busy;
  modport master(output load_valid, load_data, input load_ready, ser_out, ser_valid, frame_start, frame_last, busy);
  modport slave(input load_valid, load_data, output load_ready, ser_out, ser_valid, frame_start, frame_last, busy);
endinterface

// File: rtl/piso_bit_serializer.sv
// piso_bit_serializer: MSB-first parallel-to-serial feeder with frame markers and optional inter-word gap.
// Defining PISO_PARITY_EN appends an even-parity bit after the data bits.
module piso_bit_serializer #(
  parameter int WIDTH = 8,
  parameter int GAP_CYCLES = 0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input logic clk,
  input logic reset,
  piso_bit_serializer_if.slave bus
);
`ifdef PISO_PARITY_EN
  localparam int BITS = WIDTH + 1;
`else
  localparam int BITS = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);
  localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2;
  logic [1:0] state;
  logic [BITS-1:0] sr, frame;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gcnt;
  logic ser_out, ser_valid, frame_start, frame_last, last, xfer;
`ifdef PISO_PARITY_EN
  assign frame = {bus.load_data, ^bus.load_data};
`else
  assign frame = bus.load_data;
`endif
  assign last = state == SHIFT && cnt == '0;
  assign bus.load_ready = reset && (state == IDLE || (GAP_CYCLES == 0 && last));
  assign xfer = bus.load_valid && bus.load_ready;
  assign bus.ser_out = ser_out;
  assign bus.ser_valid = ser_valid;
  assign bus.frame_start = frame_start;
  assign bus.frame_last = frame_last;
  assign bus.busy = state != IDLE;
  // sr holds the whole frame; ser_out is registered one bit ahead of the shift
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      gcnt <= '0;
      ser_out <= IDLE_LEVEL;
      ser_valid <= 1'b0;
      frame_start <= 1'b0;
      frame_last <= 1'b0;
    end else if (xfer) begin
      state <= SHIFT;
      sr <= frame;
      cnt <= CW'(BITS - 1);
      ser_out <= frame[BITS-1];
      ser_valid <= 1'b1;
      frame_start <= 1'b1;
      frame_last <= 1'b0;
    end else if (state == SHIFT && !last) begin
      sr <= sr << 1;
      cnt <= cnt - 1'b1;
      ser_out <= sr[BITS-2];
      frame_start <= 1'b0;
      frame_last <= cnt == CW'(1);
    end else if (last) begin
      state <= GAP_CYCLES > 0 ? GAP : IDLE;
      gcnt <= GW'(GAP_CYCLES - 1);
      ser_out <= IDLE_LEVEL;
      ser_valid <= 1'b0;
      frame_start <= 1'b0;
      frame_last <= 1'b0;
    end else if (state == GAP) begin
      if (gcnt == '0) state <= IDLE;
      else gcnt <= gcnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_piso_bit_serializer.sv
// tb_piso_bit_serializer: drives a GAP_CYCLES=0 and a GAP_CYCLES=2 serializer from shared stimulus
// and checks both against a per-cycle timeline model derived from each accepted word.
module tb_piso_bit_serializer;
  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int BITS = W + 1;
`else
  localparam int BITS = W;
`endif
  logic clk = 1'b0, rst_n = 1'b0, lv = 1'b0, armed = 1'b0;
  logic [W-1:0] ld = '0;
  int checks = 0, passed = 0, fails = 0, n = 0;
  int c0[2] = '{-100, -100};
  int dend[2] = '{-1, -1};
  int gend[2] = '{-1, -1};
  int gap[2] = '{0, 2};
  logic [W-1:0] word[2];
  logic xs[2];
  always #5 clk = ~clk;
  piso_bit_serializer_if #(.WIDTH(W)) b0();
  piso_bit_serializer_if #(.WIDTH(W)) b1();
  assign b0.load_valid = lv;
  assign b0.load_data = ld;
  assign b1.load_valid = lv;
  assign b1.load_data = ld;
  piso_bit_serializer #(.WIDTH(W), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) dut0 (.clk(clk), .reset(rst_n), .bus(b0));
  piso_bit_serializer #(.WIDTH(W), .GAP_CYCLES(2), .IDLE_LEVEL(1'b0)) dut1 (.clk(clk), .reset(rst_n), .bus(b1));

  task automatic chk(input string tag, input int i, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s dut%0d cycle %0d: got %b expected %b", tag, i, n, obs, exp);
    end
  endtask

  // Word occupies cycles c0+1..dend; gap cycles follow up to gend; ready when nothing remains queued.
  function automatic logic exp_ready(input int i);
    return rst_n && (n > gend[i] || (n == gend[i] && gap[i] == 0));
  endfunction

  task automatic outs(input int i, input logic so, input logic sv, input logic fs, input logic fl, input logic bz);
    int k;
    logic d, b;
    k = n - c0[i] - 1;
    d = n > c0[i] && n <= dend[i];
    b = 1'b0;
    if (d) b = k < W ? word[i][W-1-k] : ^word[i];
    chk("ser_out", i, so, b);
    chk("ser_valid", i, sv, d);
    chk("frame_start", i, fs, d && k == 0);
    chk("frame_last", i, fl, d && n == dend[i]);
    chk("busy", i, bz, n <= gend[i]);
  endtask

  task automatic cyc(input logic v, input logic [W-1:0] d, input logic r);
    logic e[2];
    lv = v;
    ld = d;
    rst_n = r;
    #1;
    e[0] = exp_ready(0);
    e[1] = exp_ready(1);
    if (armed) begin
      chk("load_ready", 0, b0.load_ready, e[0]);
      chk("load_ready", 1, b1.load_ready, e[1]);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      xs[i] = v && e[i];
      if (xs[i]) begin
        c0[i] = n;
        word[i] = d;
        dend[i] = n + BITS;
        gend[i] = dend[i] + gap[i];
      end
      if (!r) begin
        dend[i] = n;
        gend[i] = n;
      end
    end
    if (!r) armed = 1'b1;
    n++;
    #1;
    if (armed) begin
      outs(0, b0.ser_out, b0.ser_valid, b0.frame_start, b0.frame_last, b0.busy);
      outs(1, b1.ser_out, b1.ser_valid, b1.frame_start, b1.frame_last, b1.busy);
    end
  endtask

  initial begin
    int cnt;
    logic [W-1:0] data;
    repeat (3) cyc(1'b0, '0, 1'b0);
    cyc(1'b1, 8'hA5, 1'b1);
    repeat (12) cyc(1'b0, '0, 1'b1);
    cnt = 0;
    data = 8'hF0;
    for (int t = 0; t < 40 && cnt < 2; t++) begin
      cyc(1'b1, data, 1'b1);
      if (xs[0]) begin
        cnt++;
        data = 8'h0F;
      end
    end
    repeat (14) cyc(1'b0, '0, 1'b1);
    cnt = 0;
    data = 8'hFF;
    for (int t = 0; t < 40 && cnt < 2; t++) begin
      cyc(1'b1, data, 1'b1);
      if (xs[1]) begin
        cnt++;
        data = 8'h00;
      end
    end
    repeat (14) cyc(1'b0, '0, 1'b1);
    cyc(1'b1, 8'hC3, 1'b1);
    repeat (3) cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
    repeat (12) cyc(1'b0, '0, 1'b1);
    cyc(1'b1, 8'h3C, 1'b1);
    repeat (12) cyc(1'b1, 8'h55, 1'b1);
    repeat (14) cyc(1'b0, '0, 1'b1);
    cyc(1'b1, 8'h07, 1'b1);
    repeat (12) cyc(1'b0, '0, 1'b1);
    for (int t = 0; t < 500; t++)
      cyc(1'($urandom_range(0, 1)), W'($urandom), $urandom_range(0, 59) != 0);
    repeat (14) cyc(1'b0, '0, 1'b1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
